updown_monitor: RTL and testbench

Protocol checker and decoder for the 5-bit ping-pong up/down counter bus. It samples the counter's `count` and `enable` each clock and recovers the count direction. It flags top and bottom turnarounds and detects illegal steps, latching a sticky fault after repeated errors. It also measures the full up/down period in clocks. It sits on the receiving side of the counter in the same clock domain and feeds status LEDs and the debug register block.

---
 rtl/updown_monitor.sv | 179 +++++++++++++++++
 tb/tb_updown_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_monitor.sv
// updown_monitor: protocol checker for a ping-pong up/down counter bus.
// Recovers the count direction, flags turnarounds at 0 and MAX, and detects
// illegal steps. Latches a sticky fault after ERR_LIMIT errors and measures
// the bottom-to-bottom period in clocks.
module updown_monitor #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MAX       = 31,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             locked,
  output logic             turn_top,
  output logic             turn_bot,
  output logic             err,
  output logic [3:0]       err_cnt,
  output logic             fault,
  output logic [15:0]      period,
  output logic             period_valid
);

  typedef enum logic [1:0] {
    ACQUIRE    = 2'd0,
    TRACK_UP   = 2'd1,
    TRACK_DOWN = 2'd2
  } state_t;

  // Comparisons use one extra bit so that prev+1 / prev-1 never wrap onto a
  // legal bus value.
  localparam logic [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] MAXM1_X = (WIDTH+1)'(MAX - 1);
  localparam logic [WIDTH:0] ONE_X   = (WIDTH+1)'(1);
  localparam logic [4:0]     LIMIT_X = 5'(ERR_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q;
  logic             prev_en_q;
  logic             hist_valid_q;
  logic             turn_top_q, turn_top_d;
  logic             turn_bot_q, turn_bot_d;
  logic             err_q, err_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic             fault_q, fault_d;
  logic [15:0]      per_cnt_q, per_cnt_d;
  logic             seen_bot_q, seen_bot_d;
  logic [15:0]      period_q, period_d;
  logic             period_valid_q, period_valid_d;

  logic [WIDTH:0]   cnt_x, prev_x, prev_inc, prev_dec, expect_x;
  logic             turning, step_ok;
  logic [15:0]      per_inc;

  assign cnt_x    = {1'b0, count};
  assign prev_x   = {1'b0, prev_count_q};
  assign prev_inc = prev_x + ONE_X;
  assign prev_dec = prev_x - ONE_X;
  assign per_inc  = (per_cnt_q == '1) ? '1 : per_cnt_q + 16'd1;

  // Expected next sample for the tracking states, and whether it reverses.
  always_comb begin
    expect_x = prev_x;
    turning  = 1'b0;
    if (prev_en_q) begin
      if (state_q == TRACK_UP) begin
        turning  = (prev_x == MAX_X);
        expect_x = turning ? MAXM1_X : prev_inc;
      end else begin
        turning  = (prev_x == '0);
        expect_x = turning ? ONE_X : prev_dec;
      end
    end
    step_ok = (cnt_x == expect_x) && (cnt_x <= MAX_X);
  end

  // Direction tracking, step checking and error accounting.
  always_comb begin
    state_d    = state_q;
    turn_top_d = 1'b0;
    turn_bot_d = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    fault_d    = fault_q;
    if (hist_valid_q) begin
      unique case (state_q)
        ACQUIRE: begin
          if ((prev_en_q && cnt_x == prev_inc) || (prev_x == '0 && cnt_x == ONE_X)) begin
            state_d = TRACK_UP;
          end else if ((prev_en_q && cnt_x == prev_dec) ||
                       (prev_x == MAX_X && cnt_x == MAXM1_X)) begin
            state_d = TRACK_DOWN;
          end
        end
        TRACK_UP, TRACK_DOWN: begin
          if (!step_ok) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
            if (({1'b0, err_cnt_q} + 5'd1) >= LIMIT_X) fault_d = 1'b1;
            state_d   = ACQUIRE;
          end else if (turning) begin
            if (state_q == TRACK_UP) begin
              turn_top_d = 1'b1;
              state_d    = TRACK_DOWN;
            end else begin
              turn_bot_d = 1'b1;
              state_d    = TRACK_UP;
            end
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // Bottom-to-bottom period measurement in clocks.
  always_comb begin
    per_cnt_d      = per_cnt_q;
    seen_bot_d     = seen_bot_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    if (turn_bot_d) begin
      if (seen_bot_q) begin
        period_d       = per_inc;
        period_valid_d = 1'b1;
      end
      per_cnt_d  = '0;
      seen_bot_d = 1'b1;
    end else if (state_q != ACQUIRE) begin
      per_cnt_d = per_inc;
    end
    if (state_d == ACQUIRE) seen_bot_d = 1'b0;
  end

  // State, history and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ACQUIRE;
      prev_count_q   <= '0;
      prev_en_q      <= 1'b0;
      hist_valid_q   <= 1'b0;
      turn_top_q     <= 1'b0;
      turn_bot_q     <= 1'b0;
      err_q          <= 1'b0;
      err_cnt_q      <= '0;
      fault_q        <= 1'b0;
      per_cnt_q      <= '0;
      seen_bot_q     <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= count;
      prev_en_q      <= enable;
      hist_valid_q   <= 1'b1;
      turn_top_q     <= turn_top_d;
      turn_bot_q     <= turn_bot_d;
      err_q          <= err_d;
      err_cnt_q      <= err_cnt_d;
      fault_q        <= fault_d;
      per_cnt_q      <= per_cnt_d;
      seen_bot_q     <= seen_bot_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign dir          = (state_q == TRACK_UP);
  assign locked       = (state_q != ACQUIRE);
  assign turn_top     = turn_top_q;
  assign turn_bot     = turn_bot_q;
  assign err          = err_q;
  assign err_cnt      = err_cnt_q;
  assign fault        = fault_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_updown_monitor.sv
// Bench for updown_monitor: directed vector table, directed multi-cycle
// sequences, then randomized counter traffic against a reference model.
module tb_updown_monitor;
  localparam int W    = 5;
  localparam int MAXV = 31;
  localparam int LIM  = 3;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [4:0]  count;
  logic        dir, locked, turn_top, turn_bot, err, fault, period_valid;
  logic [3:0]  err_cnt;
  logic [15:0] period;

  always #5 clk = ~clk;

  updown_monitor #(.WIDTH(W), .MAX(MAXV), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .enable(enable), .count(count),
    .dir(dir), .locked(locked), .turn_top(turn_top), .turn_bot(turn_bot),
    .err(err), .err_cnt(err_cnt), .fault(fault), .period(period),
    .period_valid(period_valid)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endfunction

  // Reference model: direction is +1/-1, or 0 when unknown.
  int m_prev, m_pen, m_hv, m_dir, m_errc, m_fault;
  int m_per, m_pv, m_pcnt, m_seen, m_tt, m_tb, m_err;

  function automatic void model(int r, int e, int c);
    int nd, nxt, turn;
    m_tt = 0; m_tb = 0; m_err = 0; m_pv = 0;
    if (r == 0) begin
      m_prev = 0; m_pen = 0; m_hv = 0; m_dir = 0; m_errc = 0; m_fault = 0;
      m_per = 0; m_pcnt = 0; m_seen = 0;
      return;
    end
    if (m_hv != 0) begin
      nd = m_dir;
      if (m_dir == 0) begin
        if ((m_pen != 0 && c == m_prev + 1) || (m_prev == 0 && c == 1)) nd = 1;
        else if ((m_pen != 0 && c == m_prev - 1) || (m_prev == MAXV && c == MAXV - 1)) nd = -1;
      end else begin
        nxt = m_prev; turn = 0;
        if (m_pen != 0) begin
          nxt = m_prev + m_dir;
          if (nxt < 0 || nxt > MAXV) begin nxt = m_prev - m_dir; turn = 1; end
        end
        if (c != nxt) begin
          m_err = 1;
          m_errc = (m_errc < 15) ? m_errc + 1 : 15;
          if (m_errc >= LIM) m_fault = 1;
          nd = 0;
        end else if (turn != 0) begin
          if (m_dir == 1) m_tt = 1; else m_tb = 1;
          nd = -m_dir;
        end
      end
      if (m_tb != 0) begin
        if (m_seen != 0) begin
          m_per = (m_pcnt + 1 > 65535) ? 65535 : m_pcnt + 1;
          m_pv  = 1;
        end
        m_pcnt = 0;
        m_seen = 1;
      end else if (m_dir != 0) begin
        m_pcnt = (m_pcnt + 1 > 65535) ? 65535 : m_pcnt + 1;
      end
      if (nd == 0) m_seen = 0;
      m_dir = nd;
    end
    m_prev = c; m_pen = e; m_hv = 1;
  endfunction

  task automatic tick(input int r, input int e, input int c);
    reset  = r[0];
    enable = e[0];
    count  = c[4:0];
    @(posedge clk);
    model(r, e, c);
    #1;
    chk("m_dir",      int'(dir),          (m_dir == 1) ? 1 : 0);
    chk("m_locked",   int'(locked),       (m_dir != 0) ? 1 : 0);
    chk("m_turn_top", int'(turn_top),     m_tt);
    chk("m_turn_bot", int'(turn_bot),     m_tb);
    chk("m_err",      int'(err),          m_err);
    chk("m_err_cnt",  int'(err_cnt),      m_errc);
    chk("m_fault",    int'(fault),        m_fault);
    chk("m_period",   int'(period),       m_per);
    chk("m_pvalid",   int'(period_valid), m_pv);
  endtask

  int cur;

  // Step the counter one value per clock toward target with enable high.
  task automatic go(input int target);
    while (cur != target) begin
      cur += (target > cur) ? 1 : -1;
      tick(1, 1, cur);
    end
  endtask

  typedef struct {
    int r, e, c;
    int lk, dr, tt, tb, er, ec, ft;
  } vec_t;

  vec_t tv[22];

  initial begin
    int rc, rd, e, r;
    reset = 1'b0; enable = 1'b0; count = '0;

    //         r  e   c   lk dr tt tb er ec ft
    tv[0]  = '{0, 0,  0,  0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1,  3,  0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 1,  5,  0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 1,  6,  1, 1, 0, 0, 0, 0, 0};
    tv[4]  = '{1, 1,  7,  1, 1, 0, 0, 0, 0, 0};
    tv[5]  = '{1, 1,  9,  0, 0, 0, 0, 1, 1, 0};
    tv[6]  = '{1, 1, 10,  1, 1, 0, 0, 0, 1, 0};
    tv[7]  = '{1, 0, 11,  1, 1, 0, 0, 0, 1, 0};
    tv[8]  = '{1, 0, 11,  1, 1, 0, 0, 0, 1, 0};
    tv[9]  = '{1, 1, 11,  1, 1, 0, 0, 0, 1, 0};
    tv[10] = '{1, 1, 12,  1, 1, 0, 0, 0, 1, 0};
    tv[11] = '{1, 0, 14,  0, 0, 0, 0, 1, 2, 0};
    tv[12] = '{1, 1, 14,  0, 0, 0, 0, 0, 2, 0};
    tv[13] = '{1, 1, 15,  1, 1, 0, 0, 0, 2, 0};
    tv[14] = '{1, 1, 14,  0, 0, 0, 0, 1, 3, 1};
    tv[15] = '{1, 1, 13,  1, 0, 0, 0, 0, 3, 1};
    tv[16] = '{1, 1, 12,  1, 0, 0, 0, 0, 3, 1};
    tv[17] = '{0, 1, 11,  0, 0, 0, 0, 0, 0, 0};
    tv[18] = '{1, 1,  1,  0, 0, 0, 0, 0, 0, 0};
    tv[19] = '{1, 1,  0,  1, 0, 0, 0, 0, 0, 0};
    tv[20] = '{1, 1,  1,  1, 1, 0, 1, 0, 0, 0};
    tv[21] = '{1, 1,  2,  1, 1, 0, 0, 0, 0, 0};

    for (int i = 0; i < 22; i++) begin
      tick(tv[i].r, tv[i].e, tv[i].c);
      chk("vec_locked",   int'(locked),   tv[i].lk);
      chk("vec_dir",      int'(dir),      tv[i].dr);
      chk("vec_turn_top", int'(turn_top), tv[i].tt);
      chk("vec_turn_bot", int'(turn_bot), tv[i].tb);
      chk("vec_err",      int'(err),      tv[i].er);
      chk("vec_err_cnt",  int'(err_cnt),  tv[i].ec);
      chk("vec_fault",    int'(fault),    tv[i].ft);
    end
    cur = 2;

    // Clean ramp: turnaround at top, then first measured period.
    go(31);
    tick(1, 1, 30); cur = 30;
    chk("ramp_turn_top", int'(turn_top), 1);
    chk("ramp_dir_down", int'(dir), 0);
    go(0);
    tick(1, 1, 1); cur = 1;
    chk("ramp_turn_bot", int'(turn_bot), 1);
    chk("ramp_pvalid", int'(period_valid), 1);
    chk("ramp_period", int'(period), 62);

    // Hold at 12 for 10 clocks while going up.
    go(11);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 12);
      chk("hold_err", int'(err), 0);
      chk("hold_dir", int'(dir), 1);
    end
    tick(1, 1, 12); cur = 12;
    go(31);
    go(0);
    tick(1, 1, 1); cur = 1;
    chk("hold_pvalid", int'(period_valid), 1);
    chk("hold_period", int'(period), 72);

    // Wrap 31 -> 0 is illegal and is not a turnaround.
    go(31);
    tick(1, 1, 0); cur = 0;
    chk("wrap_err", int'(err), 1);
    chk("wrap_turn_top", int'(turn_top), 0);
    tick(1, 1, 1); cur = 1;
    chk("wrap_relock", int'(locked), 1);

    // Reset mid-stream at 20 going down, then error-free reacquisition.
    go(31);
    go(20);
    tick(0, 1, 19);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_period", int'(period), 0);
    tick(1, 1, 18);
    tick(1, 1, 17); cur = 17;
    chk("rst_relock", int'(locked), 1);
    chk("rst_dir", int'(dir), 0);
    chk("rst_err", int'(err), 0);

    // Three skips latch fault; it survives clean ramps until reset.
    tick(1, 1, 15); tick(1, 1, 14);
    tick(1, 1, 12); tick(1, 1, 11);
    tick(1, 1, 9);  cur = 9;
    chk("fault_err", int'(err), 1);
    chk("fault_set", int'(fault), 1);
    tick(1, 1, 8); cur = 8;
    go(0);
    go(31);
    go(5);
    chk("fault_sticky", int'(fault), 1);
    chk("fault_locked", int'(locked), 1);
    tick(0, 1, 5);
    chk("fault_cleared", int'(fault), 0);

    // Randomized counter traffic with glitches and occasional resets.
    rc = 5; rd = -1;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r = ($urandom_range(0, 299) != 0) ? 1 : 0;
      tick(r, e, rc);
      if ($urandom_range(0, 39) == 0) begin
        rc = int'($urandom_range(0, MAXV));
      end else if (e != 0) begin
        if (rc + rd > MAXV || rc + rd < 0) rd = -rd;
        rc += rd;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
